// File: rtl/prio_enc_scan.sv
// prio_enc_scan: sequential priority encoder. Accepts a WIDTH-bit request
// vector over valid/ready, then emits one beat per set bit (highest index
// first by default), flagging the final beat and the all-zero vector.
// Build option: define PENC_LSB_FIRST_EN to scan lowest set bit first.
module prio_enc_scan #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_last;

  // Pick the next bit to report, decoded only from the mask register.
  always_comb begin
    sel_idx = '0;
`ifdef PENC_LSB_FIRST_EN
    // Walk downward so the lowest set bit is the last one to win.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_idx = IDX_W'(i);
    end
`else
    // Walk upward so the highest set bit is the last one to win.
    for (int i = 0; i < WIDTH; i++) begin
      if (mask_q[i]) sel_idx = IDX_W'(i);
    end
`endif
    // At most one bit set: clearing the lowest set bit leaves nothing.
    sel_last = ((mask_q & (mask_q - WIDTH'(1))) == '0);
  end

  // Next-state and output decode; outputs are forced to zero outside SCAN.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mask_d  = in_data;
          state_d = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_idx   = sel_idx;
        out_last  = sel_last;
        // The mask only reaches zero inside SCAN when the vector was empty,
        // because the last real beat always returns to IDLE.
        out_none  = (mask_q == '0);
        if (out_ready) begin
          mask_d[sel_idx] = 1'b0;
          if (sel_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pending-bit mask registers; reset abandons any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_prio_enc_scan.sv
// Directed self-checking bench for prio_enc_scan (WIDTH=8 and WIDTH=16).
// Expected scan order follows PENC_LSB_FIRST_EN when the bench is built with it.
module tb_prio_enc_scan;

`ifdef PENC_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_none8;
  logic [7:0] in_data8;
  logic [2:0] out_idx8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, out_none16;
  logic [15:0] in_data16;
  logic [3:0]  out_idx16;

  int n_cmp = 0;
  int n_bad = 0;

  prio_enc_scan #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_idx(out_idx8),
    .out_last(out_last8), .out_none(out_none8)
  );

  prio_enc_scan #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_idx(out_idx16),
    .out_last(out_last16), .out_none(out_none16)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a vector to the 8-bit DUT, waiting (bounded) for in_ready.
  task automatic send8(input string tag, input logic [7:0] d);
    int n = 0;
    while (!in_ready8 && n < 40) begin tick(); n++; end
    chk_eq({tag, " in_ready"}, in_ready8, 1'b1);
    in_valid8 = 1'b1;
    in_data8  = d;
    tick();
    in_valid8 = 1'b0;
  endtask

  // Wait (bounded) for a beat, check it, and let it be consumed on the next edge.
  task automatic beat8(input string tag, input int eidx, input bit elast, input bit enone);
    int n = 0;
    while (!out_valid8 && n < 40) begin tick(); n++; end
    chk_eq({tag, " valid"}, out_valid8, 1'b1);
    chk_eq({tag, " idx"},   out_idx8, 64'(eidx));
    chk_eq({tag, " last"},  out_last8, elast);
    chk_eq({tag, " none"},  out_none8, enone);
    tick();
  endtask

  task automatic send16(input string tag, input logic [15:0] d);
    int n = 0;
    while (!in_ready16 && n < 40) begin tick(); n++; end
    chk_eq({tag, " in_ready"}, in_ready16, 1'b1);
    in_valid16 = 1'b1;
    in_data16  = d;
    tick();
    in_valid16 = 1'b0;
  endtask

  task automatic beat16(input string tag, input int eidx, input bit elast);
    int n = 0;
    while (!out_valid16 && n < 40) begin tick(); n++; end
    chk_eq({tag, " valid"}, out_valid16, 1'b1);
    chk_eq({tag, " idx"},   out_idx16, 64'(eidx));
    chk_eq({tag, " last"},  out_last16, elast);
    chk_eq({tag, " none"},  out_none16, 1'b0);
    tick();
  endtask

  initial begin
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      in_valid8 = 1'($urandom); in_data8 = 8'($urandom); out_ready8 = 1'($urandom);
      tick();
      chk_eq("rst out_valid", out_valid8, 1'b0);
    end
    chk_eq("rst out_idx",  out_idx8, 3'd0);
    chk_eq("rst out_last", out_last8, 1'b0);
    chk_eq("rst out_none", out_none8, 1'b0);
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    rst_n = 1'b1;
    tick();
    chk_eq("post-rst in_ready",  in_ready8, 1'b1);
    chk_eq("post-rst out_valid", out_valid8, 1'b0);

    // 0x12 with out_ready high
    send8("v12", 8'b0001_0010);
    beat8("v12 b0", LSB ? 1 : 4, 1'b0, 1'b0);
    beat8("v12 b1", LSB ? 4 : 1, 1'b1, 1'b0);
    chk_eq("v12 done in_ready",  in_ready8, 1'b1);
    chk_eq("v12 done out_valid", out_valid8, 1'b0);

    // 0x84 with back-pressure for three cycles
    out_ready8 = 1'b0;
    send8("v84", 8'b1000_0100);
    for (int i = 0; i < 3; i++) begin
      chk_eq("v84 hold valid", out_valid8, 1'b1);
      chk_eq("v84 hold idx",   out_idx8, LSB ? 3'd2 : 3'd7);
      chk_eq("v84 hold last",  out_last8, 1'b0);
      chk_eq("v84 in_ready",   in_ready8, 1'b0);
      tick();
    end
    out_ready8 = 1'b1;
    beat8("v84 b0", LSB ? 2 : 7, 1'b0, 1'b0);
    beat8("v84 b1", LSB ? 7 : 2, 1'b1, 1'b0);

    // All-zero vector: exactly one beat
    send8("v00", 8'h00);
    beat8("v00 b0", 0, 1'b1, 1'b1);
    chk_eq("v00 single beat", out_valid8, 1'b0);
    chk_eq("v00 in_ready",    in_ready8, 1'b1);

    // Only bit 0 set
    send8("v01", 8'h01);
    beat8("v01 b0", 0, 1'b1, 1'b0);

    // All bits set, with a second vector offered mid-scan
    send8("vFF", 8'hFF);
    for (int j = 0; j < 8; j++) begin
      if (j == 2) begin in_valid8 = 1'b1; in_data8 = 8'h01; end
      if (j >= 2) chk_eq("vFF busy in_ready", in_ready8, 1'b0);
      beat8("vFF beat", LSB ? j : 7 - j, j == 7, 1'b0);
    end
    chk_eq("vFF gap in_ready",  in_ready8, 1'b1);
    chk_eq("vFF gap out_valid", out_valid8, 1'b0);
    tick();
    in_valid8 = 1'b0;
    beat8("vFF second", 0, 1'b1, 1'b0);
    chk_eq("vFF second done", out_valid8, 1'b0);

    // Reset in the middle of a scan
    send8("vrst", 8'hF0);
    beat8("vrst b0", LSB ? 4 : 7, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_eq("midrst out_valid", out_valid8, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("midrst no beat",  out_valid8, 1'b0);
      chk_eq("midrst in_ready", in_ready8, 1'b1);
    end

    // WIDTH=16 instance
    send16("w16", 16'h8001);
    beat16("w16 b0", LSB ? 0 : 15, 1'b0);
    beat16("w16 b1", LSB ? 15 : 0, 1'b1);
    chk_eq("w16 done", out_valid16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
